// File: rtl/piezo_rx.sv
// piezo_rx: measures half-periods of the piezo drive pair and classifies the tone into an alert code.
// Define PIEZO_RX_DIFF_CHK_EN to enable the complementary-pair check that drives diff_err.
module piezo_rx #(
    parameter int CNT_W   = 20,
    parameter int HP_MOVE = 12500,
    parameter int HP_OVR  = 8333,
    parameter int HP_BATT = 25000,
    parameter int TOL     = 256,
    parameter int CONFIRM = 4,
    parameter int SILENCE = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             audio_i,
    input  logic             audio_i_n,
    input  logic             clr_err,
    output logic [1:0]       alert,
    output logic             alert_vld,
    output logic             alert_chg,
    output logic [CNT_W-1:0] hp_meas,
    output logic             diff_err
);

    localparam logic [1:0] ST_SILENT  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int                  W1      = CNT_W + 1;
    localparam int                  MC_W    = $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0]    SIL_C   = CNT_W'(SILENCE);
    localparam logic signed [W1-1:0] TOL_S  = W1'(TOL);
    localparam logic [MC_W-1:0]     CONF_M1 = MC_W'(CONFIRM - 1);

    logic             a_s1, a_s2, a_prev, edge_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp_new;
    logic [1:0]       bin;
    logic [1:0]       state;
    logic [1:0]       cand;
    logic [MC_W-1:0]  match_cnt;

    // Edge pulse is registered so every consumer sees one aligned edge-detect cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1   <= 1'b0;
            a_s2   <= 1'b0;
            a_prev <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            a_s1   <= audio_i;
            a_s2   <= a_s1;
            a_prev <= a_s2;
            edge_q <= a_s2 ^ a_prev;
        end
    end

    assign hp_new = (cnt == SIL_C) ? SIL_C : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            hp_meas <= '0;
        end else if (edge_q) begin
            cnt     <= '0;
            hp_meas <= hp_new;
        end else if (cnt != SIL_C) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    function automatic logic near(input logic [CNT_W-1:0] hp, input int nom);
        logic signed [W1-1:0] d;
        d = $signed({1'b0, hp}) - $signed(W1'(nom));
        return (d <= TOL_S) && (d >= -TOL_S);
    endfunction

    // Over-speed is tested first so it wins if tolerance windows ever overlap.
    always_comb begin
        bin = 2'b00;
        if (near(hp_new, HP_OVR))
            bin = 2'b10;
        else if (near(hp_new, HP_BATT))
            bin = 2'b11;
        else if (near(hp_new, HP_MOVE))
            bin = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SILENT;
            cand      <= 2'b00;
            match_cnt <= '0;
            alert     <= 2'b00;
            alert_vld <= 1'b0;
            alert_chg <= 1'b0;
        end else begin
            alert_chg <= 1'b0;
            if (edge_q) begin
                case (state)
                    ST_SILENT: begin
                        state     <= ST_ACQUIRE;
                        cand      <= 2'b00;
                        match_cnt <= '0;
                    end
                    ST_ACQUIRE: begin
                        if (bin == 2'b00) begin
                            match_cnt <= '0;
                        end else if (bin == cand) begin
                            match_cnt <= match_cnt + MC_W'(1);
                            if (match_cnt == CONF_M1) begin
                                state     <= ST_LOCKED;
                                alert     <= cand;
                                alert_vld <= 1'b1;
                                alert_chg <= 1'b1;
                            end
                        end else begin
                            cand      <= bin;
                            match_cnt <= MC_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (bin != alert) begin
                            state     <= ST_ACQUIRE;
                            alert     <= 2'b00;
                            alert_vld <= 1'b0;
                            alert_chg <= 1'b1;
                            cand      <= bin;
                            match_cnt <= (bin != 2'b00) ? MC_W'(1) : '0;
                        end
                    end
                    default: state <= ST_SILENT;
                endcase
            end else if (cnt == SIL_C && state != ST_SILENT) begin
                state     <= ST_SILENT;
                alert     <= 2'b00;
                alert_vld <= 1'b0;
                alert_chg <= (state == ST_LOCKED);
            end
        end
    end

`ifdef PIEZO_RX_DIFF_CHK_EN
    logic       n_s1, n_s2;
    logic [1:0] eq_run;

    // eq_run counts prior equal cycles; the third consecutive equal cycle flags the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_s1     <= 1'b1;
            n_s2     <= 1'b1;
            eq_run   <= 2'd0;
            diff_err <= 1'b0;
        end else begin
            n_s1 <= audio_i_n;
            n_s2 <= n_s1;
            if (a_s2 == n_s2) begin
                if (eq_run != 2'd2)
                    eq_run <= eq_run + 2'd1;
            end else begin
                eq_run <= 2'd0;
            end
            if (a_s2 == n_s2 && eq_run == 2'd2)
                diff_err <= 1'b1;
            else if (clr_err)
                diff_err <= 1'b0;
        end
    end
`else
    logic unused_diff;
    assign unused_diff = audio_i_n ^ clr_err;
    assign diff_err    = 1'b0;
`endif

endmodule

// File: tb/tb_piezo_rx.sv
// tb_piezo_rx: randomized tone sequences checked against a run-length model of the classifier.
// Uses scaled-down half-periods and silence timeout so the run stays short.
module tb_piezo_rx;

    localparam int CNT_W   = 11;
    localparam int HP_MOVE = 125;
    localparam int HP_OVR  = 80;
    localparam int HP_BATT = 250;
    localparam int TOL     = 8;
    localparam int CONFIRM = 4;
    localparam int SILENCE = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             audio_i = 1'b0;
    logic             audio_i_n = 1'b1;
    logic             clr_err = 1'b0;
    logic [1:0]       alert;
    logic             alert_vld;
    logic             alert_chg;
    logic [CNT_W-1:0] hp_meas;
    logic             diff_err;

    int vectors = 0;
    int miscompares = 0;
    int seq[$];

    piezo_rx #(
        .CNT_W(CNT_W), .HP_MOVE(HP_MOVE), .HP_OVR(HP_OVR), .HP_BATT(HP_BATT),
        .TOL(TOL), .CONFIRM(CONFIRM), .SILENCE(SILENCE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .audio_i(audio_i), .audio_i_n(audio_i_n),
        .clr_err(clr_err), .alert(alert), .alert_vld(alert_vld),
        .alert_chg(alert_chg), .hp_meas(hp_meas), .diff_err(diff_err)
    );

    always #5 clk = ~clk;

    function automatic int abs_i(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [1:0] bin_of(input int hp);
        if (abs_i(hp - HP_OVR) <= TOL) return 2'b10;
        if (abs_i(hp - HP_BATT) <= TOL) return 2'b11;
        if (abs_i(hp - HP_MOVE) <= TOL) return 2'b01;
        return 2'b00;
    endfunction

    task automatic fill(input int hp, input int n);
        for (int k = 0; k < n; k++) seq.push_back(hp);
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        audio_i   = 1'b0;
        audio_i_n = 1'b1;
        clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Edge 0 after silence is discarded; afterwards the tone is locked once the trailing
    // run of identical non-zero bins reaches CONFIRM half-periods.
    task automatic run_sequence(input string name);
        int         run, chg_n, chg_pos;
        logic [1:0] last_b, b, exp_alert, prev_alert;
        logic       exp_vld, prev_vld, exp_chg;
        run = 0; last_b = 2'b00; exp_alert = 2'b00; exp_vld = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            prev_alert = exp_alert;
            prev_vld   = exp_vld;
            audio_i    = ~audio_i;
            audio_i_n  = ~audio_i;
            if (i > 0) begin
                b = bin_of(seq[i-1]);
                if (b != 2'b00 && b == last_b) run++;
                else run = (b != 2'b00) ? 1 : 0;
                last_b    = b;
                exp_vld   = (run >= CONFIRM);
                exp_alert = exp_vld ? b : 2'b00;
            end
            exp_chg = (exp_vld != prev_vld) || (exp_alert != prev_alert);
            chg_n = 0; chg_pos = 0;
            for (int j = 1; j <= seq[i]; j++) begin
                @(negedge clk);
                if (alert_chg) begin chg_n++; chg_pos = j; end
                if (j == 5) begin
                    vectors++;
                    if (alert_vld !== exp_vld || alert !== exp_alert) begin
                        miscompares++;
                        $display("[TB] FAIL %s_lock edge %0d: got vld=%b alert=%b expected vld=%b alert=%b",
                                 name, i, alert_vld, alert, exp_vld, exp_alert);
                    end
                    if (i > 0) begin
                        vectors++;
                        if (hp_meas !== CNT_W'(seq[i-1])) begin
                            miscompares++;
                            $display("[TB] FAIL %s_hp edge %0d: got %0d expected %0d", name, i, hp_meas, seq[i-1]);
                        end
                    end
                end
            end
            vectors++;
            if (chg_n != (exp_chg ? 1 : 0) || (exp_chg && chg_pos != 4)) begin
                miscompares++;
                $display("[TB] FAIL %s_chg edge %0d: got %0d pulses at cycle %0d expected %0d at cycle 4",
                         name, i, chg_n, chg_pos, exp_chg ? 1 : 0);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (alert !== 2'b00 || alert_vld !== 1'b0 || alert_chg !== 1'b0 ||
            hp_meas !== '0 || diff_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: got alert=%b vld=%b chg=%b hp=%0d err=%b expected all 0",
                     alert, alert_vld, alert_chg, hp_meas, diff_err);
        end
        do_reset();
    endtask

    task automatic test_moving_lock;
        do_reset();
        seq.delete(); fill(HP_MOVE, 6);
        run_sequence("moving");
        vectors++;
        if (alert !== 2'b01 || alert_vld !== 1'b1 || hp_meas !== CNT_W'(HP_MOVE)) begin
            miscompares++;
            $display("[TB] FAIL moving_final: got alert=%b vld=%b hp=%0d expected 01 1 %0d",
                     alert, alert_vld, hp_meas, HP_MOVE);
        end
    endtask

    task automatic test_tolerance;
        do_reset();
        seq.delete(); fill(HP_OVR + TOL, 6);
        run_sequence("tol_hi");
        vectors++;
        if (alert !== 2'b10 || alert_vld !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tol_hi_final: got alert=%b vld=%b expected 10 1", alert, alert_vld);
        end
        do_reset();
        seq.delete(); fill(HP_OVR - TOL, 6);
        run_sequence("tol_lo");
        do_reset();
        seq.delete(); fill(HP_OVR + TOL + 1, 8);
        run_sequence("tol_out");
        vectors++;
        if (alert_vld !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tol_out_final: got vld=%b expected 0", alert_vld);
        end
    endtask

    task automatic test_tone_switch;
        do_reset();
        seq.delete(); fill(HP_BATT, 6); fill(HP_OVR, 5);
        run_sequence("switch");
        vectors++;
        if (alert !== 2'b10 || alert_vld !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL switch_final: got alert=%b vld=%b expected 10 1", alert, alert_vld);
        end
    endtask

    task automatic test_silence;
        int   chg_n;
        logic vld_early, vld_late;
        logic [1:0] alert_late;
        do_reset();
        seq.delete(); fill(HP_MOVE, 5); seq.push_back(6);
        run_sequence("silence_pre");
        chg_n = 0; vld_early = 1'b0; vld_late = 1'b1; alert_late = 2'b11;
        for (int j = 7; j <= SILENCE + 10; j++) begin
            @(negedge clk);
            if (alert_chg) chg_n++;
            if (j == SILENCE + 1) vld_early = alert_vld;
            if (j == SILENCE + 8) begin vld_late = alert_vld; alert_late = alert; end
        end
        vectors++;
        if (vld_early !== 1'b1 || vld_late !== 1'b0 || alert_late !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL silence_drop: got early_vld=%b late_vld=%b late_alert=%b expected 1 0 00",
                     vld_early, vld_late, alert_late);
        end
        vectors++;
        if (chg_n != 1) begin
            miscompares++;
            $display("[TB] FAIL silence_chg: got %0d pulses expected 1", chg_n);
        end
        vectors++;
        if (hp_meas !== CNT_W'(HP_MOVE)) begin
            miscompares++;
            $display("[TB] FAIL silence_hp: got %0d expected %0d", hp_meas, HP_MOVE);
        end
    endtask

    task automatic test_random;
        int tone, len, nom;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            seq.delete();
            while (seq.size() < 30) begin
                tone = $urandom_range(0, 3);
                if (tone == 0) begin
                    seq.push_back($urandom_range(60, 300));
                end else begin
                    nom = (tone == 1) ? HP_MOVE : (tone == 2) ? HP_OVR : HP_BATT;
                    len = $urandom_range(1, 7);
                    for (int k = 0; k < len; k++)
                        seq.push_back(nom + $urandom_range(0, 2 * TOL) - TOL);
                end
            end
            run_sequence("random");
        end
    endtask

    task automatic test_reset_mid_lock;
        do_reset();
        seq.delete(); fill(HP_OVR, 5); seq.push_back(10);
        run_sequence("midlock_pre");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (alert !== 2'b00 || alert_vld !== 1'b0 || alert_chg !== 1'b0 || hp_meas !== '0) begin
            miscompares++;
            $display("[TB] FAIL midlock_async: got alert=%b vld=%b chg=%b hp=%0d expected all 0",
                     alert, alert_vld, alert_chg, hp_meas);
        end
        do_reset();
        seq.delete(); fill(HP_MOVE, 6);
        run_sequence("midlock_relock");
    endtask

    task automatic force_equal(input int n);
        audio_i_n = audio_i;
        repeat (n) @(negedge clk);
        audio_i_n = ~audio_i;
    endtask

    task automatic test_diff_check;
        do_reset();
        force_equal(2);
        repeat (6) @(negedge clk);
        vectors++;
        if (diff_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL diff_skew2: got %b expected 0", diff_err);
        end
`ifdef PIEZO_RX_DIFF_CHK_EN
        force_equal(3);
        repeat (6) @(negedge clk);
        vectors++;
        if (diff_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL diff_set: got %b expected 1", diff_err);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        vectors++;
        if (diff_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL diff_clr: got %b expected 0", diff_err);
        end
        audio_i_n = audio_i;
        clr_err   = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (diff_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL diff_set_wins: got %b expected 1", diff_err);
        end
        audio_i_n = ~audio_i;
        clr_err   = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (diff_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL diff_sticky: got %b expected 1", diff_err);
        end
`else
        force_equal(5);
        clr_err = 1'b1;
        repeat (6) @(negedge clk);
        clr_err = 1'b0;
        vectors++;
        if (diff_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL diff_tied: got %b expected 0", diff_err);
        end
`endif
    endtask

    initial begin
        $display("[TB] piezo_rx bench start");
        test_reset();
        test_moving_lock();
        test_tolerance();
        test_tone_switch();
        test_silence();
        test_random();
        test_reset_mid_lock();
        test_diff_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
